// File: rtl/ser_data_receiver.sv
// ---------------------------------------------------------------------------
// ser_data_receiver
//
// Receive-side partner of the 8-bit serial sender. It recovers one byte per
// frame from a single-wire, LSB-first stream that has no start or stop bits.
// The frame is delimited by the shared enable (en), and each bit lasts
// BIT_CYCLES clocks. The frame counter matches the sender's counter exactly,
// so rx_done rises on the same cycle as the sender's tx_done.
//
// Parameters:
//   BIT_CYCLES   clocks per bit (4..255)
//   SAMPLE_POINT offset inside a bit at which rx is sampled (1..BIT_CYCLES-2)
//   DATA_BITS    bits per frame; FRAME = DATA_BITS*BIT_CYCLES clocks
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         serial data in, LSB first (same clock domain as the sender)
//   en         frame enable, high for the whole frame
//   data       last completely received byte
//   rx_done    one-cycle pulse: data has just been updated
//   frame_err  one-cycle pulse: frame aborted by early en deassertion
//   busy       high while a frame is in progress (cnt != 0)
//
// Optional feature, macro RX_MAJORITY_EN:
//   When defined, rx is sampled at SAMPLE_POINT-1, SAMPLE_POINT and
//   SAMPLE_POINT+1, and the 2-of-3 majority is written at SAMPLE_POINT+1.
//   When undefined, rx is sampled once at SAMPLE_POINT.
// ---------------------------------------------------------------------------
module ser_data_receiver #(
  parameter int BIT_CYCLES   = 50,
  parameter int SAMPLE_POINT = 25,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 en,
  output logic [DATA_BITS-1:0] data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int FRAME = DATA_BITS * BIT_CYCLES;
  localparam int CNT_W = $clog2(FRAME);
  localparam int OFF_W = $clog2(BIT_CYCLES);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME - 1);
  localparam logic [OFF_W-1:0] OFF_LAST   = OFF_W'(BIT_CYCLES - 1);
  localparam logic [OFF_W-1:0] OFF_SAMPLE = OFF_W'(SAMPLE_POINT);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;      // mirrors the sender's frame counter
  logic [BIT_W-1:0]     bit_idx;  // cnt / BIT_CYCLES, without a divider
  logic [OFF_W-1:0]     offset;   // cnt % BIT_CYCLES
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_next;
  logic                 sample_now;
  logic                 sample_bit;

`ifdef RX_MAJORITY_EN
  localparam logic [OFF_W-1:0] OFF_PRE  = OFF_W'(SAMPLE_POINT - 1);
  localparam logic [OFF_W-1:0] OFF_VOTE = OFF_W'(SAMPLE_POINT + 1);

  logic vote_a;  // rx at SAMPLE_POINT-1
  logic vote_b;  // rx at SAMPLE_POINT

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_a <= 1'b0;
      vote_b <= 1'b0;
    end else if (en) begin
      if (offset == OFF_PRE)    vote_a <= rx;
      if (offset == OFF_SAMPLE) vote_b <= rx;
    end
  end

  // Third vote is the live rx at SAMPLE_POINT+1, where the bit is written.
  assign sample_now = en && (offset == OFF_VOTE);
  assign sample_bit = (vote_a & vote_b) | (vote_a & rx) | (vote_b & rx);
`else
  assign sample_now = en && (offset == OFF_SAMPLE);
  assign sample_bit = rx;
`endif

  // The updated shift register feeds both the register and the completion
  // load, so a bit written on the final edge of a frame is never lost.
  always_comb begin
    // NOTE: default first so every path assigns shift_next and no latch is inferred.
    shift_next = shift_q;
    if (sample_now) shift_next[bit_idx] = sample_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      offset    <= '0;
      shift_q   <= '0;
      data      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      shift_q   <= shift_next;

      if (en) begin
        state <= RECV;
        if (cnt == CNT_LAST) begin
          // Completion and wrap share this edge; a following frame starts at 0.
          cnt     <= '0;
          bit_idx <= '0;
          offset  <= '0;
          data    <= shift_next;
          rx_done <= 1'b1;
          busy    <= 1'b0;
        end else begin
          cnt  <= cnt + CNT_W'(1);
          busy <= 1'b1;
          if (offset == OFF_LAST) begin
            offset  <= '0;
            bit_idx <= bit_idx + BIT_W'(1);
          end else begin
            offset <= offset + OFF_W'(1);
          end
        end
      end else begin
        state <= IDLE;
        // Dropping en mid-frame is an abort; dropping it at cnt==0 is clean.
        if (state == RECV && cnt != '0) frame_err <= 1'b1;
        cnt     <= '0;
        bit_idx <= '0;
        offset  <= '0;
        busy    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ser_data_receiver.sv
// ---------------------------------------------------------------------------
// tb_ser_data_receiver
//
// Self-checking bench for ser_data_receiver. A behavioural sender drives rx
// and en; every transmitted byte is pushed to a scoreboard queue and popped
// when rx_done pulses. Directed steps cover reset, loopback, back-to-back
// frames, abort, reset mid-frame, boundary patterns and a one-cycle glitch.
// ---------------------------------------------------------------------------
module tb_ser_data_receiver;

  localparam int BC    = 50;
  localparam int SP    = 25;
  localparam int DB    = 8;
  localparam int FRAME = DB * BC;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          rx    = 1'b0;
  logic          en    = 1'b0;
  logic [DB-1:0] data;
  logic          rx_done;
  logic          frame_err;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_pulses = 0;
  int err_pulses = 0;
  logic prev_done = 1'b0;
  logic [7:0] exp_q[$];
  int done_times[$];

  ser_data_receiver #(
    .BIT_CYCLES  (BC),
    .SAMPLE_POINT(SP),
    .DATA_BITS   (DB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .en       (en),
    .data     (data),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: pops the expected byte on every rx_done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_done) begin
        done_pulses++;
        done_times.push_back(cyc);
        check("done_err_exclusive", {31'd0, frame_err}, 32'd0);
        check("done_single_cycle", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
        else check("scoreboard_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
      if (frame_err) err_pulses++;
    end
    prev_done = rx_done;
  end

  // Behavioural sender: one bit per BC clocks, LSB first, inputs set on the
  // falling edge. Cycle index 'glitch' gets rx inverted (-1 for none).
  task automatic send_bits(input logic [7:0] b, input int ncyc, input int glitch);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      en = 1'b1;
      rx = b[(i % FRAME) / BC];
      if (i == glitch) rx = ~rx;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en = 1'b0;
      rx = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int e0;
    logic [7:0] pats [4];
    logic [7:0] glitch_exp;
    pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h01; pats[3] = 8'h80;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_done", {31'd0, rx_done}, 32'd0);
    check("reset_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Loopback: single 8'hA5 frame, en held exactly FRAME clocks
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, FRAME, -1);
    @(negedge clk);
    en = 1'b0;
    check("loop_done_at_wrap", {31'd0, rx_done}, 32'd1);
    check("loop_data", {24'd0, data}, 32'hA5);
    check("loop_busy_after_wrap", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("loop_done_drop", {31'd0, rx_done}, 32'd0);
    check("loop_no_err", {31'd0, frame_err}, 32'd0);
    idle(2);
    check("loop_err_count", err_pulses, 32'd0);
    check("loop_done_count", done_pulses, 32'd1);

    // Back-to-back frames with en held high for 2*FRAME clocks
    n0 = done_pulses;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_bits(8'h3C, FRAME, -1);
    send_bits(8'hC3, FRAME, -1);
    idle(3);
    check("b2b_done_count", done_pulses - n0, 32'd2);
    if (done_times.size() >= 2)
      check("b2b_gap", done_times[done_times.size()-1] - done_times[done_times.size()-2], FRAME);
    else
      check("b2b_gap_missing", done_times.size(), 32'd2);
    check("b2b_data", {24'd0, data}, 32'hC3);
    check("b2b_no_err", err_pulses, 32'd0);

    // Abort: data 8'h12 first, then 200 clocks of 8'hFF and en falls
    exp_q.push_back(8'h12);
    send_bits(8'h12, FRAME, -1);
    idle(2);
    check("pre_abort_data", {24'd0, data}, 32'h12);
    n0 = done_pulses;
    send_bits(8'hFF, 200, -1);
    check("abort_busy_mid", {31'd0, busy}, 32'd1);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("abort_err_pulse", {31'd0, frame_err}, 32'd1);
    check("abort_data_kept", {24'd0, data}, 32'h12);
    check("abort_no_done", {31'd0, rx_done}, 32'd0);
    check("abort_busy_drop", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("abort_err_single", {31'd0, frame_err}, 32'd0);
    check("abort_err_count", err_pulses, 32'd1);
    check("abort_done_count", done_pulses - n0, 32'd0);

    // Reset mid-frame at cnt=150, held for 3 clocks
    n0 = done_pulses;
    e0 = err_pulses;
    send_bits(8'h81, 150, -1);
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("rst_mid_data", {24'd0, data}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, rx_done}, 32'd0);
    check("rst_mid_err", {31'd0, frame_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("rst_mid_no_err", err_pulses - e0, 32'd0);
    check("rst_mid_no_done", done_pulses - n0, 32'd0);
    exp_q.push_back(8'h81);
    send_bits(8'h81, FRAME, -1);
    idle(2);
    check("rst_recover_data", {24'd0, data}, 32'h81);

    // Boundary patterns: bit 0 and bit 7 placement
    n0 = done_pulses;
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back(pats[p]);
      send_bits(pats[p], FRAME, -1);
      idle(1);
    end
    idle(1);
    check("bound_done_count", done_pulses - n0, 32'd4);
    check("bound_last_data", {24'd0, data}, 32'h80);

    // One-cycle glitch at offset SP of bit 3 in frame 8'h08
`ifdef RX_MAJORITY_EN
    glitch_exp = 8'h08;
`else
    glitch_exp = 8'h00;
`endif
    exp_q.push_back(glitch_exp);
    send_bits(8'h08, FRAME, 3 * BC + SP);
    idle(2);
    check("glitch_data", {24'd0, data}, {24'd0, glitch_exp});

    check("sb_drained", exp_q.size(), 32'd0);
    check("total_done", done_pulses, 32'd10);
    check("total_err", err_pulses, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
